fault_map_collector: RTL and testbench

// - Downstream of the per-column result comparator in the self-test path. Each valid comparator beat carries one

---
 rtl/strait_pkg.sv | 9 +
 rtl/fault_map_collector_if.sv | 19 +
 rtl/fault_popcount.sv | 12 +
 rtl/fault_map_collector.sv | 115 +++++++++++
 tb/tb_fault_map_collector.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/strait_pkg.sv
// strait_pkg: shared widths and FSM state type for the self-test fault map collector.
package strait_pkg;
  localparam int SYSTOLIC_SIZE = 8;
  localparam int NUM_PATTERNS = 16;
  localparam int ROW_W = $clog2(SYSTOLIC_SIZE);
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
  localparam int CNT_W = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_REPORT} state_t;
endpackage

// File: rtl/fault_map_collector_if.sv
// fault_map_collector_if: comparator beat input and map row output stream of the collector.
interface fault_map_collector_if;
  import strait_pkg::*;
  logic cmp_valid;
  logic [ROW_W-1:0] cmp_row;
  logic [SYSTOLIC_SIZE-1:0] cmp_results;
  logic map_valid;
  logic map_ready;
  logic [ROW_W-1:0] map_row_idx;
  logic [SYSTOLIC_SIZE-1:0] map_row_bits;
  modport slave (
    input cmp_valid, cmp_row, cmp_results, map_ready,
    output map_valid, map_row_idx, map_row_bits
  );
  modport master (
    output cmp_valid, cmp_row, cmp_results, map_ready,
    input map_valid, map_row_idx, map_row_bits
  );
endinterface

// File: rtl/fault_popcount.sv
// fault_popcount: combinational popcount of the flattened PE fault map.
module fault_popcount
  import strait_pkg::*;
(
  input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] bits,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < SYSTOLIC_SIZE * SYSTOLIC_SIZE; i++) count = count + CNT_W'(bits[i]);
  end
endmodule

// File: rtl/fault_map_collector.sv
// fault_map_collector: accumulates comparator mismatch beats into a PE fault map and drains it row by row.
// Optional STRAIT_FAIL_CNT_EN adds per-column saturating mismatch counters on fail_cnt_flat.
module fault_map_collector
  import strait_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic test_end,
  fault_map_collector_if.slave bus,
  output logic [SYSTOLIC_SIZE-1:0] faulty_col_mask,
  output logic [CNT_W-1:0] fault_count,
  output logic busy,
  output logic done
`ifdef STRAIT_FAIL_CNT_EN
  ,
  output logic [SYSTOLIC_SIZE*PAT_W-1:0] fail_cnt_flat
`endif
);
  state_t state, state_nxt;
  logic [SYSTOLIC_SIZE-1:0] map_q [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE-1:0] map_nxt [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] map_flat;
  logic [SYSTOLIC_SIZE-1:0] mask_nxt, row_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PAT_W-1:0] pat_cnt, pat_nxt;
  logic [ROW_W-1:0] rd_idx;
  logic collecting, clear, accept, enter_report, handshake, last_row;

  assign collecting = state == ST_COLLECT;
  assign clear = start && state != ST_REPORT;
  assign accept = collecting && bus.cmp_valid && !start;
  assign pat_nxt = pat_cnt + PAT_W'(accept);
  // the final beat (count or test_end) is folded into map_nxt before the summary is latched
  assign enter_report = collecting && !start && (test_end || pat_nxt == PAT_W'(NUM_PATTERNS));
  assign handshake = state == ST_REPORT && bus.map_ready;
  assign last_row = rd_idx == ROW_W'(SYSTOLIC_SIZE - 1);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = (state == ST_IDLE && start) ? ST_COLLECT :
                enter_report ? ST_REPORT :
                (handshake && last_row) ? ST_IDLE : state;
  end

  always_comb begin
    bus.map_valid = state == ST_REPORT;
    bus.map_row_idx = state == ST_REPORT ? rd_idx : '0;
    bus.map_row_bits = state == ST_REPORT ? map_q[rd_idx] : '0;
    busy = state != ST_IDLE;
  end

  // out-of-range rows match no entry of row_hit, so such beats are dropped
  always_comb begin
    row_hit = '0;
    mask_nxt = '0;
    map_flat = '0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
      row_hit[r] = accept && bus.cmp_row == ROW_W'(r);
      map_nxt[r] = map_q[r] | (row_hit[r] ? bus.cmp_results : '0);
      map_flat[r*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] = map_nxt[r];
      mask_nxt = mask_nxt | map_nxt[r];
    end
  end

  fault_popcount u_popcount (
    .bits(map_flat),
    .count(cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      map_q <= '{default: '0};
      pat_cnt <= '0;
      rd_idx <= '0;
      faulty_col_mask <= '0;
      fault_count <= '0;
      done <= 1'b0;
    end else begin
      done <= handshake && last_row;
      if (handshake) rd_idx <= rd_idx + 1'b1;
      if (clear) begin
        map_q <= '{default: '0};
        pat_cnt <= '0;
        faulty_col_mask <= '0;
        fault_count <= '0;
      end else begin
        map_q <= map_nxt;
        pat_cnt <= pat_nxt;
        if (enter_report) begin
          faulty_col_mask <= mask_nxt;
          fault_count <= cnt_nxt;
        end
      end
    end

`ifdef STRAIT_FAIL_CNT_EN
  logic [PAT_W-1:0] fail_cnt [SYSTOLIC_SIZE];

  always_ff @(posedge clk or posedge rst)
    if (rst) fail_cnt <= '{default: '0};
    else if (clear) fail_cnt <= '{default: '0};
    else if (|row_hit)
      for (int c = 0; c < SYSTOLIC_SIZE; c++)
        if (bus.cmp_results[c] && fail_cnt[c] != '1) fail_cnt[c] <= fail_cnt[c] + 1'b1;

  always_comb begin
    fail_cnt_flat = '0;
    for (int c = 0; c < SYSTOLIC_SIZE; c++) fail_cnt_flat[c*PAT_W +: PAT_W] = fail_cnt[c];
  end
`endif
endmodule

// File: tb/tb_fault_map_collector.sv
// tb_fault_map_collector: randomized scoreboard bench; a behavioural map model predicts every drained row and summary.
module tb_fault_map_collector;
  import strait_pkg::*;
  typedef struct packed {
    logic [SYSTOLIC_SIZE*PAT_W-1:0] fc;
    logic [SYSTOLIC_SIZE-1:0] mask;
    logic [CNT_W-1:0] cnt;
  } sum_t;

  logic clk, rst, start, test_end, busy, done;
  logic [SYSTOLIC_SIZE-1:0] faulty_col_mask;
  logic [CNT_W-1:0] fault_count;
`ifdef STRAIT_FAIL_CNT_EN
  logic [SYSTOLIC_SIZE*PAT_W-1:0] fail_cnt_flat;
  int m_fail [SYSTOLIC_SIZE];
`endif
  fault_map_collector_if bus ();

  fault_map_collector dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .test_end(test_end),
    .bus(bus),
    .faulty_col_mask(faulty_col_mask),
    .fault_count(fault_count),
    .busy(busy),
    .done(done)
`ifdef STRAIT_FAIL_CNT_EN
    ,
    .fail_cnt_flat(fail_cnt_flat)
`endif
  );

  int errors = 0, checks = 0, done_seen = 0, ready_mode = 0, held = 0;
  logic [SYSTOLIC_SIZE-1:0] m_map [SYSTOLIC_SIZE];
  logic [ROW_W+SYSTOLIC_SIZE-1:0] exp_rows [$];
  sum_t exp_sums [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // consumer backpressure: random, held low, or a 3-cycle stall on row 4
  initial begin
    bus.map_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) bus.map_ready = 0;
      else if (ready_mode == 2 && bus.map_valid && bus.map_row_idx == 4 && held < 3) begin
        bus.map_ready = 0;
        held++;
      end else bus.map_ready = (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: pops expectations whenever the DUT presents a summary, a row, or done
  initial begin
    logic pv, pr, exp_done;
    logic [ROW_W-1:0] pidx;
    logic [SYSTOLIC_SIZE-1:0] pbits;
    sum_t s;
    logic [ROW_W+SYSTOLIC_SIZE-1:0] e;
    pv = 0; pr = 0; exp_done = 0; pidx = 0; pbits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        exp_done = 0;
        continue;
      end
      if (exp_done || done) begin
        chk("done_pulse", 64'(done), 64'(exp_done));
        if (done) done_seen++;
        exp_done = 0;
      end
      if (bus.map_valid && !pv) begin
        if (exp_sums.size() == 0) chk("summary_unexpected", 1, 0);
        else begin
          s = exp_sums.pop_front();
          chk("faulty_col_mask", 64'(faulty_col_mask), 64'(s.mask));
          chk("fault_count", 64'(fault_count), 64'(s.cnt));
`ifdef STRAIT_FAIL_CNT_EN
          chk("fail_cnt_flat", 64'(fail_cnt_flat), 64'(s.fc));
`endif
        end
      end
      if (pv && !pr)
        chk("row_stable", {bus.map_valid, bus.map_row_idx, bus.map_row_bits}, {1'b1, pidx, pbits});
      if (bus.map_valid && bus.map_ready) begin
        if (exp_rows.size() == 0) chk("row_unexpected", 1, 0);
        else begin
          e = exp_rows.pop_front();
          chk("row_idx", 64'(bus.map_row_idx), 64'(e[ROW_W+SYSTOLIC_SIZE-1:SYSTOLIC_SIZE]));
          chk("row_bits", 64'(bus.map_row_bits), 64'(e[SYSTOLIC_SIZE-1:0]));
        end
        if (bus.map_row_idx == ROW_W'(SYSTOLIC_SIZE - 1)) exp_done = 1;
      end
      pv = bus.map_valid; pr = bus.map_ready; pidx = bus.map_row_idx; pbits = bus.map_row_bits;
    end
  end

  task automatic begin_session();
    for (int r = 0; r < SYSTOLIC_SIZE; r++) m_map[r] = '0;
`ifdef STRAIT_FAIL_CNT_EN
    for (int c = 0; c < SYSTOLIC_SIZE; c++) m_fail[c] = 0;
`endif
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic drive_beat(input logic [ROW_W-1:0] row, input logic [SYSTOLIC_SIZE-1:0] res, input bit te);
    bus.cmp_valid = 1; bus.cmp_row = row; bus.cmp_results = res; test_end = te;
    @(posedge clk);
    #1;
    bus.cmp_valid = 0; test_end = 0;
    m_map[row] |= res;
`ifdef STRAIT_FAIL_CNT_EN
    for (int c = 0; c < SYSTOLIC_SIZE; c++) if (res[c] && m_fail[c] < (1 << PAT_W) - 1) m_fail[c]++;
`endif
  endtask

  task automatic drive_idle();
    bus.cmp_valid = 0;
    bus.cmp_row = ROW_W'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic end_pulse();
    test_end = 1;
    @(posedge clk);
    #1;
    test_end = 0;
  endtask

  task automatic zero_beats(input int n);
    for (int b = 0; b < n; b++) drive_beat(ROW_W'($urandom), '0, 0);
  endtask

  task automatic push_expect(input bit rows);
    sum_t s;
    s = '0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
      if (rows) exp_rows.push_back({ROW_W'(r), m_map[r]});
      s.mask |= m_map[r];
      s.cnt += CNT_W'($countones(m_map[r]));
    end
`ifdef STRAIT_FAIL_CNT_EN
    for (int c = 0; c < SYSTOLIC_SIZE; c++) s.fc[c*PAT_W +: PAT_W] = PAT_W'(m_fail[c]);
`endif
    exp_sums.push_back(s);
  endtask

  // called right after the session's terminating edge: DUT is in REPORT
  task automatic finish_session();
    int d0;
    push_expect(1);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    d0 = done_seen;
    for (int i = 0; i < 400 && done_seen == d0; i++) begin
      bus.cmp_valid = 1'($urandom);
      bus.cmp_row = ROW_W'($urandom);
      bus.cmp_results = SYSTOLIC_SIZE'($urandom);
      test_end = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.cmp_valid = 0;
    test_end = 0;
    chk("session_done_seen", 64'(done_seen != d0), 1);
    chk("idle_after_done", 64'(busy), 0);
  endtask

  initial begin
    int n, m;
    rst = 1; start = 0; test_end = 0;
    bus.cmp_valid = 0; bus.cmp_row = 0; bus.cmp_results = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_outputs", {bus.map_valid, busy, done, bus.map_row_idx, bus.map_row_bits},
        '0);
    chk("reset_summary", {faulty_col_mask, fault_count}, '0);

    begin_session();
    chk("busy_collect", 64'(busy), 1);
    zero_beats(NUM_PATTERNS);
    finish_session();

    begin_session();
    drive_beat(3, 8'h10, 0);
    zero_beats(NUM_PATTERNS - 1);
    finish_session();

    begin_session();
    drive_beat(2, 8'h01, 0);
    drive_beat(2, 8'h80, 0);
    drive_beat(2, 8'h00, 0);
    zero_beats(NUM_PATTERNS - 3);
    finish_session();

    held = 0;
    ready_mode = 2;
    begin_session();
    for (int b = 0; b < 5; b++) drive_beat(ROW_W'($urandom), SYSTOLIC_SIZE'($urandom), 0);
    end_pulse();
    finish_session();
    chk("bp_hold_cycles", 64'(held), 3);
    ready_mode = 0;

    begin_session();
    zero_beats(3);
    drive_beat(6, 8'h44, 1);
    finish_session();

    begin_session();
    drive_beat(5, 8'hFF, 0);
    zero_beats(2);
    begin_session();
    for (int b = 0; b < NUM_PATTERNS; b++) drive_beat(ROW_W'($urandom), SYSTOLIC_SIZE'($urandom) & 8'h0F, 0);
    finish_session();

    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(1, NUM_PATTERNS);
      m = $urandom_range(0, 1);
      begin_session();
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 3) == 0) drive_idle();
        drive_beat(ROW_W'($urandom), SYSTOLIC_SIZE'($urandom & $urandom & $urandom),
                   b == n - 1 && n < NUM_PATTERNS && m == 1);
      end
      if (n < NUM_PATTERNS && m == 0) end_pulse();
      finish_session();
    end

    ready_mode = 1;
    begin_session();
    for (int b = 0; b < NUM_PATTERNS; b++) drive_beat(ROW_W'($urandom), SYSTOLIC_SIZE'($urandom), 0);
    push_expect(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("rst_async_outputs", {bus.map_valid, busy, done, bus.map_row_idx, bus.map_row_bits}, '0);
    @(posedge clk);
    #1;
    chk("rst_edge_outputs", {bus.map_valid, busy, done, bus.map_row_idx, bus.map_row_bits}, '0);
    chk("rst_edge_summary", {faulty_col_mask, fault_count}, '0);
    rst = 0;
    exp_rows.delete();
    ready_mode = 0;

    begin_session();
    drive_beat(1, 8'h02, 1);
    finish_session();

    chk("queues_drained", 64'(exp_rows.size() + exp_sums.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
